// File: rtl/byte_assembler.sv
// Packs an 8-bit valid/ready byte stream into 32-bit words, with optional LSB-first or MSB-first lane order.
// The output slot is a single register that reloads on the same edge it drains, so back-to-back words have no bubble.
module byte_assembler #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  byte_count
);

    logic [31:0] asm_reg;
    logic [1:0]  count_reg;
    logic [31:0] out_word_reg;
    logic        out_valid_reg;

    logic [1:0]  lane_sel;
    logic [31:0] asm_next;
    logic        accept;
    logic        consume;
    logic        last_byte;

    // MSB-first fills lane 3-count, which for a 2-bit count is its complement.
    assign lane_sel  = LSB_FIRST ? count_reg : ~count_reg;
    assign last_byte = (count_reg == 2'd3);

    // The fourth byte still needs a slot that is free or draining this very cycle.
    assign in_ready = !reset && !flush && (!last_byte || !out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_reg && out_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_next[8*gi +: 8] = (lane_sel == 2'(gi)) ? in_byte : asm_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_reg       <= 32'h0;
            count_reg     <= 2'd0;
            out_word_reg  <= 32'h0;
            out_valid_reg <= 1'b0;
        end else begin
            if (flush) begin
                asm_reg   <= 32'h0;
                count_reg <= 2'd0;
            end else if (accept) begin
                count_reg <= count_reg + 2'd1;
                if (last_byte) begin
                    asm_reg      <= 32'h0;
                    out_word_reg <= asm_next;
                end else begin
                    asm_reg <= asm_next;
                end
            end

            if (accept && last_byte) begin
                out_valid_reg <= 1'b1;
            end else if (consume) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_word   = out_word_reg;
    assign out_valid  = out_valid_reg;
    assign byte_count = count_reg;

endmodule

// File: tb/tb_byte_assembler.sv
// Directed bench driving one LSB-first and one MSB-first byte_assembler with the same stream;
// per-instance queues of hand-computed words are drained by a monitor on each output handshake.
module tb_byte_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic [31:0] out_word0, out_word1;
    logic        out_valid0, out_valid1;
    logic [1:0]  byte_count0, byte_count1;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    always #5 clk = ~clk;

    byte_assembler #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready0),
        .flush(flush), .out_word(out_word0), .out_valid(out_valid0), .out_ready(out_ready),
        .byte_count(byte_count0)
    );

    byte_assembler #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready1),
        .flush(flush), .out_word(out_word1), .out_valid(out_valid1), .out_ready(out_ready),
        .byte_count(byte_count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Both instances share stimulus, so their control outputs must agree with the same expectation.
    task automatic check_ctl(input string name, input logic [1:0] cnt, input logic vld);
        check({name, " byte_count lsb"}, 32'(byte_count0), 32'(cnt));
        check({name, " byte_count msb"}, 32'(byte_count1), 32'(cnt));
        check({name, " out_valid lsb"}, 32'(out_valid0), 32'(vld));
        check({name, " out_valid msb"}, 32'(out_valid1), 32'(vld));
    endtask

    task automatic expect_word(input logic [31:0] w_lsb, input logic [31:0] w_msb);
        exp_q0.push_back(w_lsb);
        exp_q1.push_back(w_msb);
    endtask

    // Called just after a falling edge; returns after the byte has been accepted.
    task automatic put(input logic [7:0] b, output int cycles);
        logic rdy;
        in_valid = 1'b1;
        in_byte  = b;
        cycles   = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            rdy = in_ready0;
            @(negedge clk);
            cycles++;
            if (rdy) return;
        end
        check("put timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    // Look mid-low-phase so inputs driven at the falling edge have settled before the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid0 && out_ready) begin
            if (exp_q0.size() == 0) begin
                check("unexpected word lsb", out_word0, 32'hDEAD_BEEF);
            end else begin
                $display("[TB] word lsb %08h expected %08h", out_word0, exp_q0[0]);
                check("word lsb", out_word0, exp_q0.pop_front());
            end
        end
        if (!reset && out_valid1 && out_ready) begin
            if (exp_q1.size() == 0) begin
                check("unexpected word msb", out_word1, 32'hDEAD_BEEF);
            end else begin
                $display("[TB] word msb %08h expected %08h", out_word1, exp_q1[0]);
                check("word msb", out_word1, exp_q1.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic [7:0] v37[4] = '{8'h63, 8'h56, 8'hF0, 8'hB1};
        logic [7:0] v39[7] = '{8'h81, 8'h5E, 8'h89, 8'hC0, 8'h8D, 8'h99, 8'hDF};

        reset = 1'b1; in_byte = 8'h0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("in_ready during reset", 32'(in_ready0), 32'd0);
        check_ctl("reset", 2'd0, 1'b0);
        check("reset out_word lsb", out_word0, 32'h0);
        check("reset out_word msb", out_word1, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready after reset", 32'(in_ready0), 32'd1);

        // Four bytes back to back with downstream always ready.
        out_ready = 1'b1;
        expect_word(32'hB1F05663, 32'h6356F0B1);
        for (int i = 0; i < 4; i++) begin
            put(v37[i], n);
            check("stream no stall", 32'(n), 32'd1);
            check_ctl("stream count", 2'(i + 1), (i == 3));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_ctl("after single word", 2'd0, 1'b0);

        // Downstream blocked: first word held, fourth byte of the second word held back.
        out_ready = 1'b0;
        expect_word(32'hC0895E81, 32'h815E89C0);
        expect_word(32'h46DF998D, 32'h8D99DF46);
        for (int i = 0; i < 7; i++) put(v39[i], n);
        in_valid = 1'b1;
        in_byte  = 8'h46;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("in_ready blocked", 32'(in_ready0), 32'd0);
            @(negedge clk);
            check_ctl("blocked", 2'd3, 1'b1);
            check("held word lsb", out_word0, 32'hC0895E81);
            check("held word msb", out_word1, 32'h815E89C0);
        end
        out_ready = 1'b1;
        #1;
        check("in_ready draining", 32'(in_ready0), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_ctl("no bubble", 2'd0, 1'b1);
        check("next word lsb", out_word0, 32'h46DF998D);
        @(negedge clk);
        check_ctl("drained", 2'd0, 1'b0);

        // Flush mid-word, with a byte offered during the flush cycle.
        put(8'h09, n);
        put(8'hD6, n);
        flush = 1'b1;
        in_byte = 8'hEE;
        #1;
        check("in_ready during flush", 32'(in_ready0), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check_ctl("after flush", 2'd0, 1'b0);
        expect_word(32'h8484D609, 32'h09D68484);
        put(8'h09, n); put(8'hD6, n); put(8'h84, n); put(8'h84, n);
        in_valid = 1'b0;
        @(negedge clk);
        check_ctl("after flushed word", 2'd0, 1'b0);

        // Reset with a pending word and two partial bytes; neither may survive.
        out_ready = 1'b0;
        put(8'h11, n); put(8'h22, n); put(8'h33, n); put(8'h44, n);
        put(8'h55, n); put(8'h66, n);
        in_valid = 1'b0;
        check_ctl("before reset", 2'd2, 1'b1);
        reset = 1'b1;
        #1;
        check("in_ready reset mid-word", 32'(in_ready0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_ctl("after mid reset", 2'd0, 1'b0);
        check("mid reset out_word lsb", out_word0, 32'h0);
        check("mid reset out_word msb", out_word1, 32'h0);
        out_ready = 1'b1;
        expect_word(32'hD4C3B2A1, 32'hA1B2C3D4);
        put(8'hA1, n); put(8'hB2, n); put(8'hC3, n); put(8'hD4, n);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("pending lsb words", 32'(exp_q0.size()), 32'd0);
        check("pending msb words", 32'(exp_q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_assembler.md
BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
REQ-001 Parameter: LSB_FIRST, 1, first accepted byte of a word lands in out_word[7:0]; 0 means it lands in out_word[31:24].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 in_byte  input  8  byte stream data.
REQ-005 in_valid  input  1  in_byte valid.
REQ-006 in_ready  output  1  block can accept in_byte this cycle.
REQ-007 flush  input  1  discard the partially assembled word.
REQ-008 out_word  output  32  assembled word.
REQ-009 out_valid  output  1  out_word valid.
REQ-010 out_ready  input  1  downstream accepts out_word.
REQ-011 byte_count  output  2  bytes held in the partial word (0..3).

Function
REQ-012 Byte handshake: a byte is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-013 Word handshake: a word is consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-014 Assembly state is an internal 32-bit register plus byte_count; byte_count counts 0,1,2,3 and wraps to 0 on the 4th accepted byte.
REQ-015 LSB_FIRST=1: the byte accepted at count k is placed in bits [8k+7:8k].
REQ-016 LSB_FIRST=0: the byte accepted at count k is placed in bits [31-8k:24-8k].
REQ-017 Bytes 1-3 of a word always go to the assembly register; in_ready=1 when byte_count<3 and flush=0.
REQ-018 When byte_count=3 and flush=0, in_ready = !out_valid || out_ready, so the 4th byte needs a free or draining output slot.
REQ-019 in_ready=0 while flush=1.
REQ-020 On acceptance of the 4th byte, the completed word (including that byte) loads into out_word, out_valid=1 on the next cycle, and byte_count=0.
REQ-021 Latency is 1 cycle from the 4th byte handshake edge to out_valid high.
REQ-022 While out_valid=1 and out_ready=0, out_word and out_valid hold stable.
REQ-023 Word consume with no simultaneous 4th byte: out_valid=0 on the next cycle.
REQ-024 Word consume with a simultaneous 4th byte: out_valid stays 1 and out_word takes the new word, so there is no bubble.
REQ-025 Sustained throughput: one byte per cycle when out_ready=1, with no stall.
REQ-026 flush=1: byte_count=0 and the assembly register clears to 0 on the next edge.
REQ-027 flush does not affect a pending out_word or out_valid.
REQ-028 in_byte presented with in_valid during flush is not accepted.
REQ-029 The assembly register contents are unobservable until a word completes; unfilled byte lanes never reach out_word.
REQ-030 in_byte is ignored whenever in_valid=0; no state changes.

Reset
REQ-031 Reset is synchronous; on a rising edge with reset=1: out_valid=0, out_word=32'h0, byte_count=0, assembly register=0.
REQ-032 reset has priority over flush, byte handshake and word handshake in the same cycle.
REQ-033 Reset mid-word drops the partial bytes.
REQ-034 Reset with out_valid=1 drops the pending word.
REQ-035 in_ready=0 in any cycle where reset=1.
REQ-036 The cycle after reset deasserts, in_ready=1.

Verification
REQ-037 LSB_FIRST=1, out_ready=1, bytes 63,56,F0,B1 on consecutive cycles -> out_valid one cycle after B1 with out_word=32'hB1F05663; byte_count sequence 0,1,2,3,0.
REQ-038 LSB_FIRST=0, same bytes -> out_word=32'h6356F0B1.
REQ-039 out_ready=0, 8 bytes 81,5E,89,C0,8D,99,DF,46 offered back-to-back (LSB_FIRST=1) -> word 32'hC0895E81 held.
REQ-040 Continuation of REQ-039: in_ready drops with byte_count=3 holding 46 back; raising out_ready -> C0895E81 consumed, 46 accepted the same cycle, next word 32'h46DF998D with no bubble.
REQ-041 Bytes 09,D6 then flush=1 for 1 cycle, then 09,D6,84,84 -> byte_count=0 after flush; single output 32'h8484D609; no word built from the flushed bytes.
REQ-042 Reset asserted with byte_count=2 and out_valid=1 -> next cycle out_valid=0, out_word=0, byte_count=0; next 4 bytes form a clean word.
